// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared parameters for the CPU memory arbiter.
// Holds the arbiter state type, the default starvation limit and the text base address.
`default_nettype none

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_e;

   localparam int          STARVE_MAX_DEF = 4;
   localparam logic [31:0] TEXT_ADDRESS   = 32'h0040_0000;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data normally wins; fetch is forced through after STARVE_MAX consecutive data grants.
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clockCPU,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   output logic              mem_rden,
   input  logic [31:0]       mem_q,
   output logic              stall
);

   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      d_rdata_q, d_rdata_d;
   logic             d_rd_q, d_rd_d;
   logic             grant_if, grant_d;

   // Address bits outside the word index are intentionally dropped (wrap-around).
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0],
                               d_addr[31:ADDR_W+2], d_addr[1:0]};

   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (state_q == IDLE && !reset) begin
         if (d_req && !(if_req && starve_q == STARVE_LIM)) begin
            grant_d = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      d_rd_d      = d_rd_q;
      mem_address = '0;
      mem_data    = '0;
      mem_wren    = 1'b0;
      mem_rden    = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_d) begin
               mem_address = d_addr[ADDR_W+1:2];
               mem_data    = d_wdata;
               mem_wren    = d_we;
               mem_rden    = ~d_we;
               d_rd_d      = ~d_we;
               state_d     = BUSY_D;
            end else if (grant_if) begin
               mem_address = if_addr[ADDR_W+1:2];
               mem_rden    = 1'b1;
               state_d     = BUSY_IF;
            end
         end
         BUSY_IF: begin
            if_rdata_d = mem_q;
            state_d    = IDLE;
         end
         BUSY_D: begin
            // A write leaves d_rdata untouched, so only latch on reads.
            if (d_rd_q) begin
               d_rdata_d = mem_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (!if_req || grant_if) begin
         starve_d = '0;
      end else if (grant_d && starve_q != STARVE_LIM) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         d_rd_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         d_rd_q     <= d_rd_d;
      end
   end

   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign if_ready = (state_q == BUSY_IF);
   assign d_ready  = (state_q == BUSY_D);
   assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

`default_nettype wire
